// File: rtl/mem_access_unit_if.sv
// Request, data-bus and response signals of the MEM-stage access unit.
// The unit takes the slave view; pipeline and bus together take the master view.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_sig;
  logic [1:0]        req_msize;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              dreq_valid;
  logic              dreq_write;
  logic [ADDR_W-1:0] dreq_addr;
  logic [3:0]        dreq_strobe;
  logic [DATA_W-1:0] dreq_data;

  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_data;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_exc;
  logic [4:0]        resp_exccode;

  modport slave (
    input  req_valid, req_write, req_sig,
    input  req_msize, req_addr, req_wdata,
    output req_ready,
    output dreq_valid, dreq_write, dreq_addr,
    output dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok,
    input  dresp_data,
    output resp_valid, resp_rdata,
    output resp_exc, resp_exccode
  );

  modport master (
    output req_valid, req_write, req_sig,
    output req_msize, req_addr, req_wdata,
    input  req_ready,
    input  dreq_valid, dreq_write, dreq_addr,
    input  dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok,
    output dresp_data,
    input  resp_valid, resp_rdata,
    input  resp_exc, resp_exccode
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: alignment check, byte-strobed bus
// transaction, and extended load result, one request at a time.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [4:0] ADEL = 5'd4;
  localparam logic [4:0] ADES = 5'd5;

  logic [1:0]        state;
  logic              wr_q;
  logic              sig_q;
  logic [1:0]        msize_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              exc_q;
  logic [4:0]        code_q;

  logic [1:0]        off;
  logic              is_b;
  logic              is_h;
  logic [3:0]        strobe;
  logic [DATA_W-1:0] lanes;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ld;
  logic [DATA_W-1:0] cap;
  logic              mis;

  assign off  = addr_q[1:0];
  assign is_b = msize_q == 2'd0;
  assign is_h = msize_q == 2'd1;

  always_comb begin
    strobe = 4'b1111;
    unique case (1'b1)
      is_b:    strobe = 4'b0001 << off;
      is_h:    strobe = 4'b0011 << {off[1], 1'b0};
      default: strobe = 4'b1111;
    endcase
  end

  always_comb begin
    lanes = wdata_q;
    unique case (1'b1)
      is_b:    lanes = {4{wdata_q[7:0]}};
      is_h:    lanes = {2{wdata_q[15:0]}};
      default: lanes = wdata_q;
    endcase
  end

  assign shifted = bus.dresp_data >> {off, 3'b000};

  always_comb begin
    ld = shifted;
    unique case (1'b1)
      is_b:    ld = {{24{sig_q & shifted[7]}},
                     shifted[7:0]};
      is_h:    ld = {{16{sig_q & shifted[15]}},
                     shifted[15:0]};
      default: ld = shifted;
    endcase
  end

  assign cap = wr_q ? '0 : ld;

  // msize 3 decodes as a word access
  assign mis = (bus.req_msize == 2'd1 && bus.req_addr[0])
            || (bus.req_msize[1] && |bus.req_addr[1:0]);

  assign bus.req_ready    = state == S_IDLE;
  assign bus.dreq_valid   = state == S_ADDR;
  assign bus.dreq_write   = wr_q;
  assign bus.dreq_addr    = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.dreq_strobe  = wr_q ? strobe : 4'b0000;
  assign bus.dreq_data    = lanes;
  assign bus.resp_valid   = state == S_RESP;
  assign bus.resp_rdata   = rdata_q;
  assign bus.resp_exc     = exc_q;
  assign bus.resp_exccode = code_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      wr_q    <= 1'b0;
      sig_q   <= 1'b0;
      msize_q <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      exc_q   <= 1'b0;
      code_q  <= 5'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            sig_q   <= bus.req_sig;
            msize_q <= bus.req_msize;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            exc_q   <= mis;
            code_q  <= !mis ? 5'd0
                     : bus.req_write ? ADES : ADEL;
            state   <= mis ? S_RESP : S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus.dresp_addr_ok) begin
            if (bus.dresp_data_ok) begin
              rdata_q <= cap;
              state   <= S_RESP;
            end else begin
              state   <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (bus.dresp_data_ok) begin
            rdata_q <= cap;
            state   <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Executes one decoded memory request (valid/write/sig/msize/data) against the 32-bit data bus.
- Sits in the MEM stage, downstream of the per-op memory-argument decoder.
- For each request: checks alignment, drives a byte-strobed bus transaction through an address/data handshake, then returns a sign- or zero-extended load result or a write completion.
- Runs one request at a time. It stalls the pipeline through `req_ready` until the response pulse.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, bus data width. Fixed at 32 for byte-lane logic.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1=store, 0=load
- req_sig  in  1  1=SIGNED, 0=UNSIGNED (loads only)
- req_msize  in  2  0=MSIZE1, 1=MSIZE2, 2=MSIZE4; 3 is illegal and treated as MSIZE4
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- dreq_valid  out  1  bus request
- dreq_write  out  1  bus write
- dreq_addr  out  32  bus address (word-aligned: addr[1:0] forced to 0)
- dreq_strobe  out  4  byte enables (writes only; 0 for reads)
- dreq_data  out  32  lane-replicated write data
- dresp_addr_ok  in  1  bus accepted the request
- dresp_data_ok  in  1  bus data/ack returned
- dresp_data  in  32  bus read data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result (0 for stores)
- resp_exc  out  1  address error
- resp_exccode  out  5  4=AdEL, 5=AdES; 0 when no exception

Behaviour:
- Reset (asynchronous, applied mid-transaction too):
  - state=IDLE; all registered fields cleared.
  - dreq_valid=0, resp_valid=0, resp_exc=0, resp_rdata=0, resp_exccode=0, req_ready=1.
  - An in-flight bus transaction is abandoned; a late data_ok arriving after reset is ignored in IDLE.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write/sig/msize/addr/wdata.
  - Misalignment is MSIZE2 with addr[0]=1, or MSIZE4 with addr[1:0]!=0. If misaligned, go to RESP with resp_exc=1, exccode=AdES for a store or AdEL for a load; no bus activity.
  - Otherwise go to ADDR.
- ADDR:
  - dreq_valid=1. All dreq_* fields are driven from latched registers and stay stable until dresp_addr_ok.
  - On addr_ok with data_ok in the same cycle, go to RESP and capture data.
  - On addr_ok without data_ok, go to DATA.
  - Otherwise stay in ADDR.
- DATA: dreq_valid=0; wait for data_ok, capture, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE. req_ready=0 in ADDR, DATA and RESP.
- Latency: request accepted in cycle T; earliest resp_valid at T+2 (addr_ok and data_ok both at T+1). Misaligned request: resp_valid at T+1.
- Strobes (off = addr[1:0]):
  - MSIZE1: 4'b0001<<off.
  - MSIZE2: 4'b0011<<{off[1],1'b0}.
  - MSIZE4: 4'b1111.
- Write data:
  - MSIZE1: {4{wdata[7:0]}}.
  - MSIZE2: {2{wdata[15:0]}}.
  - MSIZE4: wdata.
- Load extract: shifted = dresp_data >> (8*off); take 8, 16 or 32 bits, then sign-extend if sig=1, else zero-extend.
- Stores: resp_rdata=0, resp_exc=0 on success.
- Registered outputs: resp_rdata, resp_exc and resp_exccode hold their value outside RESP; only the resp_valid qualification matters.
- req_valid arriving while busy is ignored; it is not latched.

Test Plan:
- LB, addr=0x1003, sig=1, bus returns 0x80xx_xxxx with addr_ok and data_ok at T+1 -> dreq_strobe=0, dreq_addr=0x1000, resp_valid at T+2, resp_rdata=0xFFFF_FF80.
- LHU, addr=0x2002, bus data 0xBEEF_1234, addr_ok at T+1, data_ok at T+4 -> dreq_valid high only at T+1, resp_rdata=0x0000_BEEF at T+5.
- SB, addr=0x3001, wdata=0x0000_00A5 -> dreq_strobe=4'b0010, dreq_data=0xA5A5_A5A5, dreq_write=1; addr_ok withheld 3 cycles -> fields stable throughout; resp_valid with resp_rdata=0.
- SW to 0x4002 -> no dreq_valid, resp_valid at T+1, resp_exc=1, exccode=5. LH at 0x4001 -> exccode=4.
- Assert reset in DATA state, then data_ok arrives one cycle later -> outputs at reset values, no resp_valid, next LW at 0x5000 completes normally with bus data 0x1234_5678.
- Back-to-back LW, SW with req_valid held -> second request accepted only in the cycle after the first resp_valid; req_ready=0 in between.
